// File: rtl/register_reader_pkg.sv
// Shared definitions for the register reader: FSM encoding, digit width and counter sizing.
package register_reader_pkg;

    localparam int NIBBLE_SIZE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } state_t;

    // A one-digit word still needs a 1-bit counter.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/register_reader_nibble_select.sv
// Combinational digit picker: returns digit idx of word, or 0 for an out-of-range index.
// REGREAD_MSBFIRST_EN selects most-significant-digit-first order; otherwise LSB first.
module nibble_select
    import register_reader_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic [DATASIZE-1:0]                          word,
    input  logic [cnt_width(DATASIZE/NIBBLE_SIZE)-1:0]   idx,
    output logic [NIBBLE_SIZE-1:0]                       nib
);

    localparam int STEPS = DATASIZE / NIBBLE_SIZE;
    localparam int CW    = cnt_width(STEPS);

    always_comb begin
        nib = '0;
        for (int k = 0; k < STEPS; k++) begin
            if (idx == CW'(k)) begin
`ifdef REGREAD_MSBFIRST_EN
                nib = word[DATASIZE-1-NIBBLE_SIZE*k -: NIBBLE_SIZE];
`else
                nib = word[NIBBLE_SIZE*k +: NIBBLE_SIZE];
`endif
            end
        end
    end

endmodule

// File: rtl/register_reader.sv
// Captures a register word on enb and emits it one 4-bit digit per nib_ack; first digit one cycle
// after enb, digits hold until acked, done pulses after the last ack. Order via REGREAD_MSBFIRST_EN.
module register_reader
    import register_reader_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enb,
    input  logic [DATASIZE-1:0]    data_in,
    input  logic                   nib_ack,
    output logic [NIBBLE_SIZE-1:0] nib_out,
    output logic                   nib_vld,
    output logic                   busy,
    output logic                   done
);

    localparam int STEPS = DATASIZE / NIBBLE_SIZE;
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t                   state;
    logic [DATASIZE-1:0]      shadow;
    logic [CW-1:0]            cnt;

    logic [DATASIZE-1:0]      sel_word;
    logic [CW-1:0]            sel_idx;
    logic [NIBBLE_SIZE-1:0]   sel_nib;

    // In IDLE the first digit comes straight from data_in so it can be registered on the capture edge;
    // afterwards the picker looks one digit ahead of the counter.
    always_comb begin
        sel_word = shadow;
        sel_idx  = cnt + CW'(1);
        if (state == IDLE) begin
            sel_word = data_in;
            sel_idx  = '0;
        end
    end

    nibble_select #(.DATASIZE(DATASIZE)) u_nibble_select (
        .word (sel_word),
        .idx  (sel_idx),
        .nib  (sel_nib)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shadow  <= '0;
            cnt     <= '0;
            nib_out <= '0;
            nib_vld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (enb) begin
                        shadow  <= data_in;
                        cnt     <= '0;
                        nib_out <= sel_nib;
                        nib_vld <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (nib_ack) begin
                        if (cnt == LAST) begin
                            nib_out <= '0;
                            nib_vld <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            cnt     <= cnt + CW'(1);
                            nib_out <= sel_nib;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    nib_out <= '0;
                    nib_vld <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_reader.sv
// Directed bench for register_reader (16-bit and 4-bit instances) with a digit scoreboard queue.
module tb_register_reader;

    logic        clk;
    logic        rst;
    logic        enb;
    logic [15:0] data_in;
    logic        nib_ack;
    logic [3:0]  nib_out;
    logic        nib_vld;
    logic        busy;
    logic        done;

    logic        enb4;
    logic [3:0]  data4;
    logic        ack4;
    logic [3:0]  nib_out4;
    logic        nib_vld4;
    logic        busy4;
    logic        done4;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    register_reader #(.DATASIZE(16)) u_dut (
        .clk(clk), .rst(rst), .enb(enb), .data_in(data_in), .nib_ack(nib_ack),
        .nib_out(nib_out), .nib_vld(nib_vld), .busy(busy), .done(done)
    );

    register_reader #(.DATASIZE(4)) u_dut4 (
        .clk(clk), .rst(rst), .enb(enb4), .data_in(data4), .nib_ack(ack4),
        .nib_out(nib_out4), .nib_vld(nib_vld4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int k = 0; k < 4; k++) begin
`ifdef REGREAD_MSBFIRST_EN
            exp_q.push_back(4'((w >> (12 - 4 * k)) & 16'hF));
`else
            exp_q.push_back(4'((w >> (4 * k)) & 16'hF));
`endif
        end
    endtask

    // Capture w, then ack every gap cycles; optionally poke data_in/enb mid-SEND and enb in DONE.
    task automatic send_word(input logic [15:0] w, input int gap, input bit poke, input bit enb_in_done);
        int cyc;
        data_in = w;
        enb     = 1'b1;
        push_word(w);
        tick();
        enb = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            chk("vld_in_send", 32'(nib_vld), 32'd1);
            chk("busy_in_send", 32'(busy), 32'd1);
            chk("no_early_done", 32'(done), 32'd0);
            chk("digit", 32'(nib_out), 32'(exp_q[0]));
            nib_ack = ((cyc % gap) == gap - 1);
            if (poke && cyc == 1) begin
                data_in = 16'hFFFF;
                enb     = 1'b1;
            end else begin
                enb = 1'b0;
            end
            tick();
            if (nib_ack) void'(exp_q.pop_front());
            cyc++;
        end
        nib_ack = 1'b0;
        enb     = 1'b0;
        chk("drained", 32'(exp_q.size()), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("vld_in_done", 32'(nib_vld), 32'd0);
        chk("nib_zero_in_done", 32'(nib_out), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        enb = enb_in_done;
        tick();
        enb = 1'b0;
        chk("done_cleared", 32'(done), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
        chk("idle_vld", 32'(nib_vld), 32'd0);
        tick();
        chk("not_queued", 32'(nib_vld), 32'd0);
        chk("no_second_done", 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; data_in = '0; nib_ack = 1'b0;
        enb4 = 1'b0; data4 = '0; ack4 = 1'b0;
        tick();
        tick();
        chk("rst_nib", 32'(nib_out), 32'd0);
        chk("rst_vld", 32'(nib_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst4_vld", 32'(nib_vld4), 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back acks, held high across the capture edge.
        nib_ack = 1'b1;
        send_word(16'hAAAA, 1, 1'b0, 1'b0);

        // Slow consumer: digits must hold until acked.
        send_word(16'h5A3C, 3, 1'b0, 1'b0);

        // data_in change and a second enb during SEND are ignored.
        send_word(16'h5A3C, 3, 1'b1, 1'b0);

        // enb in the DONE cycle is dropped.
        send_word(16'h0F1E, 2, 1'b0, 1'b1);

        // Reset after the second digit is acked.
        data_in = 16'hBEEF;
        enb     = 1'b1;
        tick();
        enb     = 1'b0;
        nib_ack = 1'b1;
        tick();
        tick();
        nib_ack = 1'b0;
        chk("pre_rst_vld", 32'(nib_vld), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_vld", 32'(nib_vld), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_nib", 32'(nib_out), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        chk("abort_no_done", 32'(done), 32'd0);
        send_word(16'h1234, 1, 1'b0, 1'b0);

        // Single-digit instance: first ack goes straight to DONE.
        data4 = 4'h9;
        enb4  = 1'b1;
        tick();
        enb4  = 1'b0;
        data4 = 4'h3;
        chk("d4_vld", 32'(nib_vld4), 32'd1);
        chk("d4_digit", 32'(nib_out4), 32'h9);
        chk("d4_busy", 32'(busy4), 32'd1);
        tick();
        chk("d4_hold", 32'(nib_out4), 32'h9);
        ack4 = 1'b1;
        tick();
        ack4 = 1'b0;
        chk("d4_done", 32'(done4), 32'd1);
        chk("d4_vld_off", 32'(nib_vld4), 32'd0);
        tick();
        chk("d4_done_off", 32'(done4), 32'd0);
        chk("d4_busy_off", 32'(busy4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
